mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage MIPS pipeline.
- Sequences each access with a req/ready handshake toward memory.
- Produces per-stage stall requests that are ORed into the hazard unit's stallF/stallD/flush logic.
- Keeps a saturating stall-cycle counter and a sticky timeout flag for debug.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, max cycles waiting on mem_ready before err_timeout sets; legal range 1..2^CW-1.
- CW, 16, width of the stall-cycle counter and the timeout counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch wants an instruction word; held until if_valid
- if_addr  in  AW  fetch address (pcF); stable while if_req
- dm_req  in  1  memory stage access (memreadM|memwriteM); held until dm_valid
- dm_we  in  1  1 = store, 0 = load; stable while dm_req
- dm_addr  in  AW  data address (aluoutM)
- dm_wdata  in  DW  store data (writedataM)
- mem_req  out  1  request to memory
- mem_we  out  1  write enable to memory
- mem_addr  out  AW  address to memory
- mem_wdata  out  DW  write data to memory
- mem_ready  in  1  one-cycle pulse: memory completed the current access
- mem_rdata  in  DW  read data, valid with mem_ready
- if_valid  out  1  one-cycle pulse: if_rdata holds fetched word
- if_rdata  out  DW  registered instruction word
- dm_valid  out  1  one-cycle pulse: access done; dm_rdata valid for loads
- dm_rdata  out  DW  registered load data
- stall_if  out  1  to hazard unit: freeze F/D
- stall_mem  out  1  to hazard unit: freeze entire pipeline
- stall_cycles  out  CW  saturating count of cycles with stall_if|stall_mem
- err_timeout  out  1  sticky; set on TIMEOUT expiry

Behaviour:
- Reset (synchronous, active-high, clk rising edge): state IDLE. mem_req, mem_we, if_valid, dm_valid and err_timeout are 0. mem_addr, mem_wdata, if_rdata, dm_rdata and stall_cycles are 0.
- FSM states: IDLE, BUSY_D, BUSY_I, DONE.
- IDLE:
  - dm_req has priority over if_req, because the older instruction wins.
  - dm_req → BUSY_D; mem_addr, mem_we and mem_wdata are latched from the dm_* inputs.
  - else if_req → BUSY_I; mem_addr is latched from if_addr, mem_we=0.
  - Grant takes effect on the next edge; mem_req=1 from the first BUSY cycle.
- BUSY_D / BUSY_I:
  - mem_req held at 1; address and data held stable.
  - On mem_ready: capture mem_rdata into dm_rdata (BUSY_D, loads only) or if_rdata (BUSY_I), and go to DONE.
  - mem_req drops to 0 in DONE.
- DONE:
  - The matching valid (dm_valid or if_valid) is 1 for exactly this cycle.
  - Next state is IDLE unconditionally. No new grant is issued in DONE, because the requester's req is still asserted for the completed access this cycle.
- Minimum latency: request seen in IDLE to valid is 2 cycles plus memory wait. Back-to-back accesses have 1 idle cycle between them.
- Stores: dm_valid pulses; dm_rdata is unchanged.
- stall_if = if_req & ~if_valid. stall_mem = dm_req & ~dm_valid. Both are combinational from registered state only (no path from mem_ready).
- Simultaneous if_req and dm_req: data is served first. stall_if stays high through both accesses. Fetch is served right after. No starvation, because the pipeline advances between data accesses.
- mem_ready in IDLE or DONE is ignored.
- Timeout:
  - A wait counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT, err_timeout sets and stays set until reset.
  - The FSM keeps waiting; no abort.
- stall_cycles increments when stall_if|stall_mem, and saturates at all-ones.
- Reset mid-access: returns to IDLE with mem_req=0 on the next edge. A late mem_ready is ignored. Requesters re-issue after reset.
- Requester protocol violation (req dropped while BUSY): access completes anyway; the valid pulse still occurs and is ignored by the pipeline.

Decomposition:
- Shared package mips_mem_pkg holds:
  - state encoding constants (IDLE=2'd0, BUSY_D=2'd1, BUSY_I=2'd2, DONE=2'd3);
  - AW/DW defaults.
- One natural sub-module: sat_counter, parameterised width, with clear/inc/saturate. It is instantiated twice: stall_cycles, and the timeout wait counter with a compare.

Test Plan:
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x0000_0040; mem_ready 3 cycles after mem_req with rdata 0x2008_0005.
  - Response: mem_addr=0x40, mem_we=0; if_valid pulses once with if_rdata=0x2008_0005; stall_if high until that cycle; stall_cycles=5.
- Collision:
  - Stimulus: if_req and dm_req (load, addr 0x100) rise together; mem_ready immediate each time.
  - Response: data granted first, dm_valid at cycle 2; if_valid at cycle 5; stall_if high cycles 0–4.
- Store:
  - Stimulus: dm_req, dm_we=1, addr 0x200, wdata 0xDEAD_BEEF.
  - Response: mem_we=1, mem_wdata=0xDEAD_BEEF held until mem_ready; dm_valid pulses; dm_rdata unchanged.
- Timeout:
  - Stimulus: TIMEOUT=4, mem_ready withheld 10 cycles.
  - Response: err_timeout rises on the 4th BUSY cycle and stays set after the later mem_ready and the completed access.
- Reset mid-access:
  - Stimulus: assert reset during BUSY_I, then pulse mem_ready the cycle after reset drops.
  - Response: mem_req=0, all outputs at reset values, no if_valid pulse.
- Saturation:
  - Stimulus: CW=4, continuous stalls for 20 cycles.
  - Response: stall_cycles holds at 15.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared constants for the unified-memory port arbiter.
// State encoding and default bus widths.
package mips_mem_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_D = 2'd1;
  localparam logic [1:0] BUSY_I = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  function automatic logic is_busy(
    input logic [1:0] s
  );
    return (s == BUSY_D) || (s == BUSY_I);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic full;

  assign full = &q;

  // Count up on inc, hold once saturated.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && !full) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port memory.
// Data wins ties; each access ends in a one-cycle DONE.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic [CW-1:0] stall_cycles,
  output logic          err_timeout
);

  // Last wait count that still lets one more
  // miss reach TIMEOUT on the next edge.
  localparam logic [CW-1:0] LIMIT =
    CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          busy;
  logic          grant;
  logic          inc_wait;
  logic          stall_any;
  logic [CW-1:0] wait_q;

  assign busy      = is_busy(state);
  assign grant     = (state == IDLE)
                   & (dm_req | if_req);
  assign inc_wait  = busy & ~mem_ready;

  // Valids are registered, so the stalls never
  // see mem_ready combinationally.
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;
  assign stall_any = stall_if | stall_mem;

  sat_counter #(
    .W (CW)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .clr   (grant),
    .inc   (inc_wait),
    .q     (wait_q)
  );

  sat_counter #(
    .W (CW)
  ) u_stall (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (stall_any),
    .q     (stall_cycles)
  );

  // Grant, hold the bus, capture read data, pulse valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dm_req) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (if_req) begin
            state    <= BUSY_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            dm_valid <= 1'b1;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        DONE: begin
          // Requester still holds req for the
          // finished access, so no grant here.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky flag once a wait hits TIMEOUT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_timeout <= 1'b0;
    end else if (inc_wait && wait_q >= LIMIT) begin
      err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed tables,
// corner sequences, random run against a model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          dm_valid;
  logic [DW-1:0] dm_rdata;
  logic          stall_if;
  logic          stall_mem;
  logic [CW-1:0] stall_cycles;
  logic          err_timeout;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO),
    .CW      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .if_valid     (if_valid),
    .if_rdata     (if_rdata),
    .dm_valid     (dm_valid),
    .dm_rdata     (dm_rdata),
    .stall_if     (stall_if),
    .stall_mem    (stall_mem),
    .stall_cycles (stall_cycles),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    if_req    = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reference model: who owns the memory, whether
  // this is the completion cycle, and the latched
  // request/response values.
  int          m_own;
  bit          m_vi, m_vd;
  bit          m_we, m_err;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_ifr, m_dmr;
  int          m_wait, m_sc;

  always @(posedge clk) begin
    if (reset) begin
      m_own = 0; m_vi = 0; m_vd = 0;
      m_we = 0; m_err = 0;
      m_addr = 0; m_wdata = 0;
      m_ifr = 0; m_dmr = 0;
      m_wait = 0; m_sc = 0;
    end else begin
      if (((if_req && !m_vi) ||
           (dm_req && !m_vd)) && m_sc < SMAX)
        m_sc = m_sc + 1;
      if (m_vi || m_vd) begin
        m_vi = 0;
        m_vd = 0;
      end else if (m_own != 0) begin
        if (mem_ready) begin
          if (m_own == 1) begin
            m_vd = 1;
            if (!m_we) m_dmr = mem_rdata;
          end else begin
            m_vi = 1;
            m_ifr = mem_rdata;
          end
          m_own = 0;
          m_we = 0;
        end else begin
          m_wait = m_wait + 1;
          if (m_wait >= TO) m_err = 1;
        end
      end else if (dm_req) begin
        m_own = 1; m_wait = 0;
        m_we = dm_we; m_addr = dm_addr;
        m_wdata = dm_wdata;
      end else if (if_req) begin
        m_own = 2; m_wait = 0;
        m_we = 0; m_addr = if_addr;
      end
    end
  end

  typedef struct {
    bit          ifr;
    bit          dmr;
    bit          rdy;
    logic [31:0] rdata;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_ifv;
    bit          e_dmv;
    bit          e_sif;
    bit          e_smem;
    int          e_sc;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tv[14];

  function automatic vec_t mk(
    bit ifr, bit dmr, bit rdy,
    logic [31:0] rdata,
    bit e_req, logic [31:0] e_addr,
    bit e_ifv, bit e_dmv,
    bit e_sif, bit e_smem,
    int e_sc, logic [31:0] e_rd
  );
    vec_t v;
    v.ifr = ifr; v.dmr = dmr; v.rdy = rdy;
    v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr;
    v.e_ifv = e_ifv; v.e_dmv = e_dmv;
    v.e_sif = e_sif; v.e_smem = e_smem;
    v.e_sc = e_sc; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      if_req    = tv[r].ifr;
      dm_req    = tv[r].dmr;
      mem_ready = tv[r].rdy;
      mem_rdata = tv[r].rdata;
      mid();
      chk($sformatf("row%0d_mem_req", r),
          64'(mem_req), 64'(tv[r].e_req));
      if (tv[r].e_req) begin
        chk($sformatf("row%0d_addr", r),
            64'(mem_addr), 64'(tv[r].e_addr));
        chk($sformatf("row%0d_we", r),
            64'(mem_we), 64'(0));
      end
      chk($sformatf("row%0d_if_valid", r),
          64'(if_valid), 64'(tv[r].e_ifv));
      chk($sformatf("row%0d_dm_valid", r),
          64'(dm_valid), 64'(tv[r].e_dmv));
      chk($sformatf("row%0d_stall_if", r),
          64'(stall_if), 64'(tv[r].e_sif));
      chk($sformatf("row%0d_stall_mem", r),
          64'(stall_mem), 64'(tv[r].e_smem));
      chk($sformatf("row%0d_stall_cycles", r),
          64'(stall_cycles), 64'(tv[r].e_sc));
      if (tv[r].e_ifv)
        chk($sformatf("row%0d_if_rdata", r),
            64'(if_rdata), 64'(tv[r].e_rd));
      if (tv[r].e_dmv)
        chk($sformatf("row%0d_dm_rdata", r),
            64'(dm_rdata), 64'(tv[r].e_rd));
      tick();
    end
  endtask

  initial begin
    bit seen_i, seen_d;
    logic [31:0] junk;
    junk = 32'hBAD0_0000;

    // Single fetch (rows 0-6), collision (7-13).
    tv[0]  = mk(1,0,0,junk, 0,0,  0,0,1,0,0,0);
    tv[1]  = mk(1,0,0,junk, 1,32'h40,0,0,1,0,1,0);
    tv[2]  = mk(1,0,0,junk, 1,32'h40,0,0,1,0,2,0);
    tv[3]  = mk(1,0,0,junk, 1,32'h40,0,0,1,0,3,0);
    tv[4]  = mk(1,0,1,32'h2008_0005,
                1,32'h40,0,0,1,0,4,0);
    tv[5]  = mk(1,0,0,junk, 0,0,1,0,0,0,5,
                32'h2008_0005);
    tv[6]  = mk(0,0,0,junk, 0,0,0,0,0,0,5,0);
    tv[7]  = mk(1,1,0,junk, 0,0,0,0,1,1,0,0);
    tv[8]  = mk(1,1,1,32'h1111_1111,
                1,32'h100,0,0,1,1,1,0);
    tv[9]  = mk(1,1,0,junk, 0,0,0,1,1,0,2,
                32'h1111_1111);
    tv[10] = mk(1,0,0,junk, 0,0,0,0,1,0,3,0);
    tv[11] = mk(1,0,1,32'h2222_2222,
                1,32'h40,0,0,1,0,4,0);
    tv[12] = mk(1,0,0,junk, 0,0,1,0,0,0,5,
                32'h2222_2222);
    tv[13] = mk(0,0,0,junk, 0,0,0,0,0,0,5,0);

    if_addr   = 32'h40;
    dm_addr   = 32'h100;
    dm_wdata  = 32'h0;
    mem_rdata = 32'h0;
    do_reset();

    mid();
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_mem_wdata", 64'(mem_wdata), 0);
    chk("rst_if_valid", 64'(if_valid), 0);
    chk("rst_dm_valid", 64'(dm_valid), 0);
    chk("rst_if_rdata", 64'(if_rdata), 0);
    chk("rst_dm_rdata", 64'(dm_rdata), 0);
    chk("rst_stall_cycles", 64'(stall_cycles), 0);
    chk("rst_err", 64'(err_timeout), 0);
    tick();

    run_rows(0, 6);
    do_reset();
    run_rows(7, 13);

    // Store: bus held until ready, load data kept.
    dm_req = 1; dm_we = 1;
    dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    mid(); tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) mem_ready = 1;
      mid();
      chk("st_mem_req", 64'(mem_req), 1);
      chk("st_mem_we", 64'(mem_we), 1);
      chk("st_addr", 64'(mem_addr), 64'h200);
      chk("st_wdata", 64'(mem_wdata),
          64'hDEAD_BEEF);
      tick();
    end
    mem_ready = 0;
    mid();
    chk("st_dm_valid", 64'(dm_valid), 1);
    chk("st_dm_rdata", 64'(dm_rdata),
        64'h1111_1111);
    chk("st_req_drop", 64'(mem_req), 0);
    tick();
    dm_req = 0; dm_we = 0;
    mid();
    chk("st_valid_once", 64'(dm_valid), 0);
    tick();

    // Timeout: ten busy cycles without ready.
    do_reset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    mid(); tick();
    for (int k = 1; k <= 10; k++) begin
      mid();
      chk($sformatf("to_err_b%0d", k),
          64'(err_timeout), 64'(k >= 5));
      chk("to_mem_req", 64'(mem_req), 1);
      tick();
    end
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    mid(); tick();
    mem_ready = 0;
    mid();
    chk("to_dm_valid", 64'(dm_valid), 1);
    chk("to_dm_rdata", 64'(dm_rdata),
        64'h1234_5678);
    chk("to_err_done", 64'(err_timeout), 1);
    tick();
    dm_req = 0;
    mid();
    chk("to_err_idle", 64'(err_timeout), 1);
    tick();

    // Reset in the middle of a fetch.
    do_reset();
    if_req = 1; if_addr = 32'h80;
    mid(); tick();
    mid();
    chk("rm_busy", 64'(mem_req), 1);
    reset = 1; if_req = 0;
    tick();
    reset = 0;
    mem_ready = 1; mem_rdata = 32'h5555_5555;
    mid();
    chk("rm_mem_req", 64'(mem_req), 0);
    chk("rm_addr", 64'(mem_addr), 0);
    chk("rm_if_valid", 64'(if_valid), 0);
    chk("rm_stall_cycles", 64'(stall_cycles), 0);
    tick();
    mem_ready = 0;
    mid();
    chk("rm_late_valid", 64'(if_valid), 0);
    chk("rm_late_rdata", 64'(if_rdata), 0);
    chk("rm_late_req", 64'(mem_req), 0);
    tick();

    // Saturation of the stall counter.
    do_reset();
    if_req = 1; if_addr = 32'h44;
    for (int k = 0; k < 20; k++) begin
      mid();
      if (k == 15)
        chk("sat_at15", 64'(stall_cycles), 15);
      tick();
    end
    mid();
    chk("sat_hold", 64'(stall_cycles), 15);
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tick();
    if_req = 0;
    tick();

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      mid();
      chk("rnd_mem_req", 64'(mem_req),
          64'(m_own != 0));
      if (m_own != 0) begin
        chk("rnd_addr", 64'(mem_addr),
            64'(m_addr));
        chk("rnd_we", 64'(mem_we), 64'(m_we));
        if (m_we)
          chk("rnd_wdata", 64'(mem_wdata),
              64'(m_wdata));
      end
      chk("rnd_if_valid", 64'(if_valid),
          64'(m_vi));
      chk("rnd_dm_valid", 64'(dm_valid),
          64'(m_vd));
      chk("rnd_if_rdata", 64'(if_rdata),
          64'(m_ifr));
      chk("rnd_dm_rdata", 64'(dm_rdata),
          64'(m_dmr));
      chk("rnd_stall_if", 64'(stall_if),
          64'(if_req && !m_vi));
      chk("rnd_stall_mem", 64'(stall_mem),
          64'(dm_req && !m_vd));
      chk("rnd_stall_cycles", 64'(stall_cycles),
          64'(m_sc));
      chk("rnd_err", 64'(err_timeout),
          64'(m_err));
      seen_i = m_vi;
      seen_d = m_vd;
      tick();
      reset = ($urandom_range(99) == 0);
      if (!if_req) begin
        if ($urandom_range(2) == 0) begin
          if_req = 1;
          if_addr = $urandom;
        end
      end else if (seen_i) begin
        if_req = $urandom_range(1);
        if_addr = $urandom;
      end
      if (!dm_req) begin
        if ($urandom_range(3) == 0) begin
          dm_req = 1;
          dm_we = $urandom_range(1);
          dm_addr = $urandom;
          dm_wdata = $urandom;
        end
      end else if (seen_d) begin
        dm_req = $urandom_range(1);
        dm_we = $urandom_range(1);
        dm_addr = $urandom;
        dm_wdata = $urandom;
      end
      if (reset) begin
        if_req = 0;
        dm_req = 0;
      end
      mem_ready = ($urandom_range(2) == 0);
      mem_rdata = $urandom;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
